// File: rtl/ysyx_25060173_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FSM state encoding is fixed at REQ=0, WAIT=1, OUT=2, ERR=3 so that waveforms read the same everywhere.
package ysyx_25060173_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2,
    ST_ERR  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ACCESS   = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: one outstanding read on a valid/ready memory port,
// a one-entry instruction buffer towards the core, and a sticky terminal error state.
module ysyx_25060173_ifu
  import ysyx_25060173_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,

  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,

  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] next_pc,

  output logic            fetch_err,
  output logic [1:0]      err_cause,
  output logic [XLEN-1:0] err_pc
);

  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_INST);

  ifu_state_e      state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] inst_q,      inst_d;
  logic [XLEN-1:0] inst_pc_q,   inst_pc_d;
  logic            err_q,       err_d;
  logic [1:0]      err_cause_q, err_cause_d;
  logic [XLEN-1:0] err_pc_q,    err_pc_d;

  always_comb begin
    // NOTE: every _d takes its current value first, so no path through the case leaves a latch behind.
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    err_d       = err_q;
    err_cause_d = err_cause_q;
    err_pc_d    = err_pc_q;

    case (state_q)
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (mem_resp_err) begin
            err_d       = 1'b1;
            err_cause_d = ERR_ACCESS;
            err_pc_d    = pc_q;
            state_d     = ST_ERR;
          end else begin
            inst_d    = mem_resp_data;
            inst_pc_d = pc_q;
            state_d   = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        // The core's next PC is only trusted on the handshake; a misaligned target is fatal.
        if (inst_ready) begin
          if (is_word_aligned(next_pc[1:0])) begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end else begin
            err_d       = 1'b1;
            err_cause_d = ERR_MISALIGN;
            err_pc_d    = next_pc;
            state_d     = ST_ERR;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every register, so an in-flight response can never survive it.
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_WORD;
      inst_pc_q   <= RESET_PC;
      err_q       <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign mem_req_valid  = (state_q == ST_REQ);
  assign mem_req_addr   = pc_q;
  assign mem_resp_ready = (state_q == ST_WAIT);
  assign inst_valid     = (state_q == ST_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = err_q;
  assign err_cause      = err_cause_q;
  assign err_pc         = err_pc_q;

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Scoreboard bench for the fetch unit: directed phases push expected requests and instructions,
// independent monitors pop and compare whenever the DUT completes a handshake.
module tb_ysyx_25060173_ifu;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    int          gap;
  } inst_exp_t;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] next_pc;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic [31:0] err_pc;

  logic        np_override;
  logic [31:0] np_val;
  logic [31:0] mem_data;
  logic [31:0] err_addr;

  logic [31:0] req_q[$];
  inst_exp_t   inst_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign next_pc = np_override ? np_val : inst_pc + 32'd4;

  ysyx_25060173_ifu #(
    .XLEN    (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_data (mem_resp_data),
    .mem_resp_err  (mem_resp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .next_pc       (next_pc),
    .fetch_err     (fetch_err),
    .err_cause     (err_cause),
    .err_pc        (err_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT presented %h with nothing expected", name, val);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_inst(input logic [31:0] word, input logic [31:0] pc, input int gap);
    inst_exp_t e;
    e.word = word;
    e.pc   = pc;
    e.gap  = gap;
    inst_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((inst_q.size() != 0 || req_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(inst_q.size() + req_q.size()), 32'd0);
  endtask

  task automatic wait_err(input string name, input int budget);
    int n = 0;
    while (fetch_err !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_fetch_err"}, 32'(fetch_err), 32'd1);
  endtask

  // Memory model: zero-wait, response valid in the cycle after the request handshake, reset with the DUT.
  initial begin
    logic        pend;
    logic [31:0] a;
    logic        req_fire, resp_fire, rst_s;
    logic [31:0] req_addr_s;
    pend = 1'b0;
    a    = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      rst_s      = rst;
      req_fire   = mem_req_valid === 1'b1 && mem_req_ready === 1'b1;
      resp_fire  = mem_resp_valid === 1'b1 && mem_resp_ready === 1'b1;
      req_addr_s = mem_req_addr;
      @(posedge clk);
      #1;
      if (rst_s === 1'b1) begin
        pend = 1'b0;
      end else begin
        if (resp_fire) pend = 1'b0;
        if (req_fire) begin
          pend = 1'b1;
          a    = req_addr_s;
        end
      end
      mem_resp_valid = pend;
      mem_resp_data  = pend ? mem_data : 32'd0;
      mem_resp_err   = pend && (a == err_addr);
    end
  end

  // Request monitor.
  initial forever begin
    logic [31:0] exp_addr;
    @(negedge clk);
    if (rst === 1'b0 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (req_q.size() == 0) unexpected("req_unexpected", mem_req_addr);
      else begin
        exp_addr = req_q.pop_front();
        check("req_addr", mem_req_addr, exp_addr);
      end
    end
  end

  // Instruction monitor.
  initial begin
    int last_hs;
    inst_exp_t e;
    last_hs = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
        if (inst_q.size() == 0) unexpected("inst_unexpected", inst_pc);
        else begin
          e = inst_q.pop_front();
          check("inst_word", inst, e.word);
          check("inst_pc", inst_pc, e.pc);
          if (e.gap != 0) check("inst_gap", 32'(cyc - last_hs), 32'(e.gap));
        end
        last_hs = cyc;
      end
    end
  end

  initial begin
    int quiet;
    rst = 1'b1;
    mem_req_ready = 1'b0;
    inst_ready = 1'b1;
    np_override = 1'b0;
    np_val = 32'd0;
    mem_data = 32'h0010_0093;
    err_addr = 32'h0000_0001;
    tick();
    tick();

    check("rst_req_valid",  32'(mem_req_valid),  32'd1);
    check("rst_req_addr",   mem_req_addr,        32'h8000_0000);
    check("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid),     32'd0);
    check("rst_inst",       inst,                32'h0000_0013);
    check("rst_inst_pc",    inst_pc,             32'h8000_0000);
    check("rst_fetch_err",  32'(fetch_err),      32'd0);
    check("rst_err_cause",  32'(err_cause),      32'd0);
    check("rst_err_pc",     err_pc,              32'd0);

    // Back-to-back stream at full throughput.
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0004);
    req_q.push_back(32'h8000_0008);
    push_inst(32'h0010_0093, 32'h8000_0000, 0);
    push_inst(32'h0010_0093, 32'h8000_0004, 3);
    push_inst(32'h0010_0093, 32'h8000_0008, 3);
    mem_req_ready = 1'b1;
    rst = 1'b0;
    drain("stream", 40);
    mem_req_ready = 1'b0;
    check("stream_next_valid", 32'(mem_req_valid), 32'd1);
    check("stream_next_addr",  mem_req_addr,       32'h8000_000C);

    // Memory not ready for 5 cycles, then one accepted request.
    rst = 1'b1;
    mem_data = 32'h00a0_0513;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", 32'(mem_req_valid), 32'd1);
      check("stall_req_addr",  mem_req_addr,       32'h8000_0000);
      tick();
    end
    req_q.push_back(32'h8000_0000);
    inst_ready = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("stall_one_req",    32'(req_q.size()),   32'd0);
    check("stall_resp_ready", 32'(mem_resp_ready), 32'd1);
    tick();

    // Core stalls for 4 cycles, then redirects to 80000100.
    for (int i = 0; i < 4; i++) begin
      check("hold_valid",  32'(inst_valid),    32'd1);
      check("hold_inst",   inst,               32'h00a0_0513);
      check("hold_pc",     inst_pc,            32'h8000_0000);
      check("hold_no_req", 32'(mem_req_valid), 32'd0);
      tick();
    end
    push_inst(32'h00a0_0513, 32'h8000_0000, 0);
    req_q.push_back(32'h8000_0100);
    np_override = 1'b1;
    np_val = 32'h8000_0100;
    inst_ready = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("redirect_addr", mem_req_addr, 32'h8000_0100);
    tick();
    mem_req_ready = 1'b0;
    tick();
    check("redirect_valid",   32'(inst_valid), 32'd1);
    check("redirect_inst_pc", inst_pc,         32'h8000_0100);

    // Access fault on the third fetch; reset is applied while the core is stalled in OUT.
    rst = 1'b1;
    np_override = 1'b0;
    inst_ready = 1'b1;
    err_addr = 32'h8000_0008;
    mem_data = 32'h0010_0093;
    tick();
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0004);
    req_q.push_back(32'h8000_0008);
    push_inst(32'h0010_0093, 32'h8000_0000, 0);
    push_inst(32'h0010_0093, 32'h8000_0004, 0);
    mem_req_ready = 1'b1;
    rst = 1'b0;
    drain("fault", 40);
    wait_err("fault", 10);
    check("fault_cause",      32'(err_cause),      32'd1);
    check("fault_err_pc",     err_pc,              32'h8000_0008);
    check("fault_inst_valid", 32'(inst_valid),     32'd0);
    check("fault_req_valid",  32'(mem_req_valid),  32'd0);
    check("fault_resp_ready", 32'(mem_resp_ready), 32'd0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req_valid !== 1'b0) quiet++;
    end
    check("fault_quiet_cycles", 32'(quiet),     32'd0);
    check("fault_sticky",       32'(fetch_err), 32'd1);

    // Misaligned next PC, then reset clears the error.
    rst = 1'b1;
    err_addr = 32'h0000_0001;
    np_override = 1'b1;
    np_val = 32'h8000_0006;
    mem_data = 32'h0000_0297;
    tick();
    req_q.push_back(32'h8000_0000);
    push_inst(32'h0000_0297, 32'h8000_0000, 0);
    rst = 1'b0;
    wait_err("misalign", 20);
    check("misalign_cause",     32'(err_cause),     32'd2);
    check("misalign_err_pc",    err_pc,             32'h8000_0006);
    check("misalign_req_valid", 32'(mem_req_valid), 32'd0);
    drain("misalign", 1);
    rst = 1'b1;
    tick();
    check("clear_req_valid", 32'(mem_req_valid), 32'd1);
    check("clear_req_addr",  mem_req_addr,       32'h8000_0000);
    check("clear_fetch_err", 32'(fetch_err),     32'd0);
    check("clear_err_cause", 32'(err_cause),     32'd0);
    check("clear_err_pc",    err_pc,             32'd0);

    // Reset in WAIT while the response is presented in the same cycle.
    np_override = 1'b0;
    mem_data = 32'h02a0_0093;
    req_q.push_back(32'h8000_0000);
    rst = 1'b0;
    tick();
    check("race_resp_valid", 32'(mem_resp_valid), 32'd1);
    check("race_resp_ready", 32'(mem_resp_ready), 32'd1);
    rst = 1'b1;
    tick();
    check("race_inst_valid", 32'(inst_valid),    32'd0);
    check("race_inst",       inst,               32'h0000_0013);
    check("race_req_valid",  32'(mem_req_valid), 32'd1);
    check("race_req_addr",   mem_req_addr,       32'h8000_0000);
    req_q.push_back(32'h8000_0000);
    rst = 1'b0;
    inst_ready = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    tick();
    check("refetch_valid", 32'(inst_valid), 32'd1);
    check("refetch_inst",  inst,            32'h02a0_0093);
    check("refetch_pc",    inst_pc,         32'h8000_0000);

    // Self-loop refetch, then a jump to the top word of the address space.
    rst = 1'b1;
    np_override = 1'b1;
    np_val = 32'h8000_0000;
    mem_data = 32'h0000_006f;
    inst_ready = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'hFFFF_FFFC);
    push_inst(32'h0000_006f, 32'h8000_0000, 0);
    push_inst(32'h0000_006f, 32'h8000_0000, 3);
    push_inst(32'h0000_006f, 32'hFFFF_FFFC, 3);
    rst = 1'b0;
    tick();
    tick();
    tick();
    np_val = 32'hFFFF_FFFC;
    drain("wrap", 40);
    mem_req_ready = 1'b0;
    check("wrap_req_valid", 32'(mem_req_valid), 32'd1);
    check("wrap_req_addr",  mem_req_addr,       32'hFFFF_FFFC);

    tick();
    tick();
    check("final_req_queue",  32'(req_q.size()),  32'd0);
    check("final_inst_queue", 32'(inst_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
